// File: rtl/udp_payload_commit_if.sv
// Signal bundle between the UDP header parser, the payload commit controller and the payload consumer.
// out_valid/out_ready: a byte moves on every cycle where both are high; once out_valid rises it stays high
// and out_data/out_last hold until that byte is taken. The parser side (in_*) has no backpressure.
interface udp_payload_commit_if #(
  parameter int ADDR_WIDTH = 11
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_eof;
  logic                in_err;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [ADDR_WIDTH:0] out_len;
  logic                frame_commit;
  logic                frame_drop;
  logic [15:0]         drop_cnt;
  logic [1:0]          wr_state;
  logic                rd_state;

  modport master (
    output in_data, in_valid, in_eof, in_err, out_ready,
    input  out_data, out_valid, out_last, out_len, frame_commit, frame_drop, drop_cnt,
    input  wr_state, rd_state
  );

  modport slave (
    input  in_data, in_valid, in_eof, in_err, out_ready,
    output out_data, out_valid, out_last, out_len, frame_commit, frame_drop, drop_cnt,
    output wr_state, rd_state
  );
endinterface

// File: rtl/udp_payload_commit_ctrl.sv
// Store-and-forward payload buffer: bytes land in a circular RAM, are published only on a clean
// end-of-frame, and committed frames are streamed out one at a time on a valid/ready byte port.
module udp_payload_commit_ctrl #(
  parameter int ADDR_WIDTH     = 11,
  parameter int LEN_ADDR_WIDTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  udp_payload_commit_if.slave bus
);
  localparam int PW     = ADDR_WIDTH + 1;
  localparam int LPW    = LEN_ADDR_WIDTH + 1;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int LDEPTH = 2 ** LEN_ADDR_WIDTH;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_RX = 2'd1, W_DROP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_STREAM = 1'b1} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [7:0]            ram [DEPTH];
  logic [PW-1:0]         len_mem [LDEPTH];
  logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr, eof_ptr, used, len_head, fetch_rem;
  logic [ADDR_WIDTH-1:0] fetch_ptr;
  logic [LPW-1:0]        len_wr, len_rd;
  logic                  ram_full, len_full, len_empty;
  logic                  in_frame, overflow, wr_en;
  logic                  fetch_en, fetch_last, pop_o;
  logic [7:0]            ram_q;
  logic                  ram_q_valid, ram_q_last;
  logic [7:0]            ob_data [4];
  logic [3:0]            ob_last;
  logic [1:0]            ob_head, ob_tail;
  logic [2:0]            ob_cnt;
  logic                  out_valid_i, out_last_i;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    used       = wr_ptr - rd_ptr;
    ram_full   = (used == PW'(DEPTH));
    len_full   = ((len_wr - len_rd) == LPW'(LDEPTH));
    len_empty  = (len_wr == len_rd);
    len_head   = len_mem[len_rd[LEN_ADDR_WIDTH-1:0]];
    // A byte seen in W_IDLE opens a frame, so it is handled exactly like a byte in W_RX.
    in_frame   = (w_state == W_RX) || ((w_state == W_IDLE) && bus.in_valid);
    overflow   = bus.in_valid && ram_full;
    wr_en      = in_frame && bus.in_valid && !ram_full && !bus.in_err;
    eof_ptr    = wr_ptr + PW'(bus.in_valid);
    out_valid_i = (ob_cnt != 3'd0);
    out_last_i  = out_valid_i && ob_last[ob_head];
    pop_o       = out_valid_i && bus.out_ready;
    fetch_en    = 1'b0;
    fetch_last  = 1'b0;
    if (r_state == R_IDLE) begin
      fetch_en   = !len_empty;
      fetch_last = (len_head == PW'(1));
    end else begin
      // At most three bytes in flight or buffered, so the four-entry output buffer never overruns.
      fetch_en   = (fetch_rem != '0) && ((ob_cnt + 3'(ram_q_valid)) < 3'd3);
      fetch_last = (fetch_rem == PW'(1));
    end
  end

  assign bus.out_valid = out_valid_i;
  assign bus.out_last  = out_last_i;
  assign bus.out_data  = out_valid_i ? ob_data[ob_head] : 8'h00;
  assign bus.wr_state  = w_state;
  assign bus.rd_state  = r_state;

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr[ADDR_WIDTH-1:0]] <= bus.in_data;
    if (fetch_en) ram_q <= ram[fetch_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state          <= W_IDLE;
      wr_ptr           <= '0;
      commit_ptr       <= '0;
      len_wr           <= '0;
      bus.frame_commit <= 1'b0;
      bus.frame_drop   <= 1'b0;
      bus.drop_cnt     <= '0;
    end else begin
      bus.frame_commit <= 1'b0;
      bus.frame_drop   <= 1'b0;
      case (w_state)
        W_IDLE, W_RX: begin
          if (in_frame) begin
            if (bus.in_err) begin
              wr_ptr         <= commit_ptr;
              bus.frame_drop <= 1'b1;
              bus.drop_cnt   <= sat_inc(bus.drop_cnt);
              w_state        <= W_IDLE;
            end else if (overflow) begin
              wr_ptr <= commit_ptr;
              // An overflowing byte that also ends the frame closes it here rather than in W_DROP.
              if (bus.in_eof) begin
                bus.frame_drop <= 1'b1;
                bus.drop_cnt   <= sat_inc(bus.drop_cnt);
                w_state        <= W_IDLE;
              end else begin
                w_state <= W_DROP;
              end
            end else if (bus.in_eof) begin
              if (!len_full) begin
                len_mem[len_wr[LEN_ADDR_WIDTH-1:0]] <= eof_ptr - commit_ptr;
                len_wr           <= len_wr + LPW'(1);
                commit_ptr       <= eof_ptr;
                wr_ptr           <= eof_ptr;
                bus.frame_commit <= 1'b1;
              end else begin
                wr_ptr         <= commit_ptr;
                bus.frame_drop <= 1'b1;
                bus.drop_cnt   <= sat_inc(bus.drop_cnt);
              end
              w_state <= W_IDLE;
            end else begin
              if (bus.in_valid) wr_ptr <= wr_ptr + PW'(1);
              w_state <= W_RX;
            end
          end else if (bus.in_err) begin
            bus.frame_drop <= 1'b1;
            bus.drop_cnt   <= sat_inc(bus.drop_cnt);
          end
        end
        W_DROP: begin
          if (bus.in_eof || bus.in_err) begin
            bus.frame_drop <= 1'b1;
            bus.drop_cnt   <= sat_inc(bus.drop_cnt);
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // The length entry is retired only after the frame's last byte, so the FIFO counts frames in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      rd_ptr      <= '0;
      fetch_ptr   <= '0;
      fetch_rem   <= '0;
      len_rd      <= '0;
      ram_q_valid <= 1'b0;
      ram_q_last  <= 1'b0;
      ob_head     <= '0;
      ob_tail     <= '0;
      ob_cnt      <= '0;
      ob_last     <= '0;
      bus.out_len <= '0;
    end else begin
      ram_q_valid <= fetch_en;
      ram_q_last  <= fetch_last;
      if (fetch_en) fetch_ptr <= fetch_ptr + ADDR_WIDTH'(1);
      if (ram_q_valid) begin
        ob_data[ob_tail] <= ram_q;
        ob_last[ob_tail] <= ram_q_last;
        ob_tail          <= ob_tail + 2'd1;
      end
      if (pop_o) begin
        ob_head <= ob_head + 2'd1;
        rd_ptr  <= rd_ptr + PW'(1);
      end
      ob_cnt <= ob_cnt + 3'(ram_q_valid) - 3'(pop_o);
      case (r_state)
        R_IDLE: begin
          if (!len_empty) begin
            bus.out_len <= len_head;
            fetch_rem   <= len_head - PW'(1);
            r_state     <= R_STREAM;
          end
        end
        R_STREAM: begin
          if (fetch_en) fetch_rem <= fetch_rem - PW'(1);
          if (pop_o && out_last_i) begin
            len_rd  <= len_rd + LPW'(1);
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
